minhash_bottomk_sorter: RTL and testbench

- Streaming bottom-k sorter for the MinHash pipeline, placed between the hasher and the sketch output.
- Accepts one (signature, k-mer index) pair per cycle and keeps the SKETCH_DEPTH smallest signatures in ascending order.
- On end-of-sequence it drains the sketch in ascending order, then clears itself for the next sequence.
- Generalises the fixed 32-bit/8-bit sorter entry to parametric widths and depth, and adds an optional duplicate-suppression mode.

---
 rtl/minhash_bottomk_sorter_pkg.sv | 22 ++
 rtl/minhash_bottomk_sorter_cell.sv | 48 ++++
 rtl/minhash_bottomk_sorter.sv | 158 +++++++++++++++
 tb/tb_minhash_bottomk_sorter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/minhash_bottomk_sorter_pkg.sv
// Shared constants, state encoding and pair type for the MinHash bottom-k sorter.
package minhash_bottomk_sorter_pkg;

  localparam int unsigned HASHER_SORTER_SIGNATURE       = 32;
  localparam int unsigned SORTER_INDICE_LEN             = 8;
  localparam int unsigned SORTER_EXTENDER_INDICES_COUNT = 4;

  localparam int unsigned MINHASH_SIG_W        = HASHER_SORTER_SIGNATURE;
  localparam int unsigned MINHASH_IDX_W        = SORTER_INDICE_LEN;
  localparam int unsigned MINHASH_SKETCH_DEPTH = SORTER_EXTENDER_INDICES_COUNT;

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } sorter_state_e;

  typedef struct packed {
    logic [HASHER_SORTER_SIGNATURE-1:0] signature;
    logic [SORTER_INDICE_LEN-1:0]       index;
  } signature_index_pack;

endpackage

// File: rtl/minhash_bottomk_sorter_cell.sv
// One sketch slot: holds a (signature, index) pair and flags how it compares to the incoming one.
module minhash_sketch_cell
  import minhash_bottomk_sorter_pkg::*;
#(
  parameter int unsigned SIG_W = MINHASH_SIG_W,
  parameter int unsigned IDX_W = MINHASH_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             sel_new,
  input  logic [SIG_W-1:0] in_signature,
  input  logic [IDX_W-1:0] in_index,
  input  logic             up_valid,
  input  logic [SIG_W-1:0] up_signature,
  input  logic [IDX_W-1:0] up_index,
  output logic             valid,
  output logic [SIG_W-1:0] signature,
  output logic [IDX_W-1:0] index,
  output logic             le,
  output logic             eq
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      valid     <= 1'b0;
      signature <= '0;
      index     <= '0;
    end else if (load) begin
      if (sel_new) begin
        valid     <= 1'b1;
        signature <= in_signature;
        index     <= in_index;
      end else begin
        valid     <= up_valid;
        signature <= up_signature;
        index     <= up_index;
      end
    end
  end

  always_comb begin
    le = valid && (signature <= in_signature);
    eq = valid && (signature == in_signature);
  end

endmodule

// File: rtl/minhash_bottomk_sorter.sv
// Streaming bottom-k sorter: keeps the SKETCH_DEPTH smallest signatures, drains them ascending.
module minhash_bottomk_sorter
  import minhash_bottomk_sorter_pkg::*;
#(
  parameter int unsigned SIG_W        = MINHASH_SIG_W,
  parameter int unsigned IDX_W        = MINHASH_IDX_W,
  parameter int unsigned SKETCH_DEPTH = MINHASH_SKETCH_DEPTH,
  parameter bit          DEDUP        = 1'b1,
  localparam int unsigned CNT_W       = $clog2(SKETCH_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIG_W-1:0] in_signature,
  input  logic [IDX_W-1:0] in_index,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIG_W-1:0] out_signature,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic [CNT_W-1:0] sketch_count
);

  sorter_state_e    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [SKETCH_DEPTH-1:0] cell_valid, cell_le, cell_eq, cell_load, cell_sel_new;
  logic [SIG_W-1:0]        cell_sig [SKETCH_DEPTH];
  logic [IDX_W-1:0]        cell_idx [SKETCH_DEPTH];

  logic             accept, insert, drop, full, out_fire, clear;
  logic [CNT_W-1:0] pos;
  logic [SIG_W-1:0] head_sig;
  logic [IDX_W-1:0] head_idx;

  for (genvar i = 0; i < SKETCH_DEPTH; i++) begin : g_cell
    logic             up_valid;
    logic [SIG_W-1:0] up_sig;
    logic [IDX_W-1:0] up_idx;

    if (i == 0) begin : g_head
      assign up_valid = 1'b0;
      assign up_sig   = '0;
      assign up_idx   = '0;
    end else begin : g_body
      assign up_valid = cell_valid[i-1];
      assign up_sig   = cell_sig[i-1];
      assign up_idx   = cell_idx[i-1];
    end

    minhash_sketch_cell #(
      .SIG_W (SIG_W),
      .IDX_W (IDX_W)
    ) u_cell (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (clear),
      .load         (cell_load[i]),
      .sel_new      (cell_sel_new[i]),
      .in_signature (in_signature),
      .in_index     (in_index),
      .up_valid     (up_valid),
      .up_signature (up_sig),
      .up_index     (up_idx),
      .valid        (cell_valid[i]),
      .signature    (cell_sig[i]),
      .index        (cell_idx[i]),
      .le           (cell_le[i]),
      .eq           (cell_eq[i])
    );
  end

  // Slots stay sorted, so the number of le flags is the stable insertion position.
  always_comb begin
    pos = '0;
    for (int i = 0; i < SKETCH_DEPTH; i++) begin
      pos = pos + CNT_W'(cell_le[i]);
    end
  end

  always_comb begin
    in_ready = rst_n && (state_q == FILL);
    accept   = in_valid && in_ready;
    full     = (count_q == CNT_W'(SKETCH_DEPTH));
    drop     = (DEDUP && (|cell_eq)) || (full && (pos == CNT_W'(SKETCH_DEPTH)));
    insert   = accept && !drop;
    for (int i = 0; i < SKETCH_DEPTH; i++) begin
      cell_load[i]    = insert && (CNT_W'(i) >= pos);
      cell_sel_new[i] = (CNT_W'(i) == pos);
    end
  end

  always_comb begin
    head_sig = '0;
    head_idx = '0;
    for (int i = 0; i < SKETCH_DEPTH; i++) begin
      if (rd_ptr_q == CNT_W'(i)) begin
        head_sig = cell_sig[i];
        head_idx = cell_idx[i];
      end
    end
  end

  always_comb begin
    out_valid     = (state_q == DRAIN);
    out_signature = out_valid ? head_sig : '0;
    out_index     = out_valid ? head_idx : '0;
    out_last      = out_valid && (rd_ptr_q == (count_q - CNT_W'(1)));
    out_fire      = out_valid && out_ready;
    clear         = out_fire && out_last;
    sketch_count  = count_q;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    unique case (state_q)
      FILL: begin
        if (insert && !full) begin
          count_d = count_q + CNT_W'(1);
        end
        if (accept && in_last) begin
          state_d  = DRAIN;
          rd_ptr_d = '0;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (out_last) begin
            state_d  = FILL;
            count_d  = '0;
            rd_ptr_d = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FILL;
      count_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_minhash_bottomk_sorter.sv
// Directed bench for the bottom-k sorter; a second instance runs with duplicate suppression off.
module tb_minhash_bottomk_sorter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_signature;
  logic [7:0]  in_index;
  logic        in_last;

  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [31:0] out_signature;
  logic [7:0]  out_index;
  logic [2:0]  sketch_count;

  logic        nd_in_valid, nd_in_ready, nd_out_valid, nd_out_ready, nd_out_last;
  logic [31:0] nd_out_signature;
  logic [7:0]  nd_out_index;
  logic [2:0]  nd_sketch_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  minhash_bottomk_sorter #(.DEDUP(1'b1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_signature  (in_signature),
    .in_index      (in_index),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_signature (out_signature),
    .out_index     (out_index),
    .out_last      (out_last),
    .sketch_count  (sketch_count)
  );

  minhash_bottomk_sorter #(.DEDUP(1'b0)) dut_nd (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (nd_in_valid),
    .in_ready      (nd_in_ready),
    .in_signature  (in_signature),
    .in_index      (in_index),
    .in_last       (in_last),
    .out_valid     (nd_out_valid),
    .out_ready     (nd_out_ready),
    .out_signature (nd_out_signature),
    .out_index     (nd_out_index),
    .out_last      (nd_out_last),
    .sketch_count  (nd_sketch_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input bit nd, input logic [31:0] sig, input logic [7:0] idx,
                      input logic last);
    @(negedge clk);
    in_signature = sig;
    in_index     = idx;
    in_last      = last;
    if (nd) nd_in_valid = 1'b1;
    else    in_valid    = 1'b1;
    check("in_ready_fill", 64'(nd ? nd_in_ready : in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    nd_in_valid = 1'b0;
    in_last     = 1'b0;
  endtask

  task automatic expect_out(input bit nd, input logic [31:0] sig, input logic [7:0] idx,
                            input logic last);
    int n = 0;
    @(negedge clk);
    while (!(nd ? nd_out_valid : out_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("out_valid_timeout", 64'd0, 64'd1);
    check("out_sig",  64'(nd ? nd_out_signature : out_signature), 64'(sig));
    check("out_idx",  64'(nd ? nd_out_index : out_index), 64'(idx));
    check("out_last", 64'(nd ? nd_out_last : out_last), 64'(last));
    if (nd) nd_out_ready = 1'b1;
    else    out_ready    = 1'b1;
    @(posedge clk);
    #1;
    out_ready    = 1'b0;
    nd_out_ready = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    nd_in_valid  = 1'b0;
    in_signature = '0;
    in_index     = '0;
    in_last      = 1'b0;
    out_ready    = 1'b0;
    nd_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_count",     64'(sketch_count), 64'd0);
    check("rst_out_sig",   64'(out_signature), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic fill
    send(0, 50, 0, 0);
    send(0, 10, 1, 0);
    send(0, 40, 2, 0);
    send(0, 20, 3, 1);
    @(negedge clk);
    check("fill_count",       64'(sketch_count), 64'd4);
    check("drain_in_ready",   64'(in_ready), 64'd0);
    expect_out(0, 10, 1, 0);
    expect_out(0, 20, 3, 0);
    expect_out(0, 40, 2, 0);
    expect_out(0, 50, 0, 1);
    @(negedge clk);
    check("basic_in_ready_after", 64'(in_ready), 64'd1);
    check("basic_count_after",    64'(sketch_count), 64'd0);

    // Eviction and drop at the max
    send(0, 50, 0, 0);
    send(0, 10, 1, 0);
    send(0, 40, 2, 0);
    send(0, 20, 3, 0);
    send(0, 5,  4, 0);
    send(0, 45, 5, 0);
    send(0, 60, 6, 1);
    expect_out(0, 5,  4, 0);
    expect_out(0, 10, 1, 0);
    expect_out(0, 20, 3, 0);
    expect_out(0, 40, 2, 1);

    // Dedup on
    send(0, 7, 0, 0);
    send(0, 7, 1, 0);
    send(0, 3, 2, 1);
    @(negedge clk);
    check("dedup_count", 64'(sketch_count), 64'd2);
    expect_out(0, 3, 2, 0);
    expect_out(0, 7, 0, 1);

    // Dedup off: stable tie ordering
    send(1, 7, 0, 0);
    send(1, 7, 1, 0);
    send(1, 3, 2, 1);
    @(negedge clk);
    check("nodedup_count", 64'(nd_sketch_count), 64'd3);
    expect_out(1, 3, 2, 0);
    expect_out(1, 7, 0, 0);
    expect_out(1, 7, 1, 1);

    // Back-pressure
    send(0, 50, 0, 0);
    send(0, 10, 1, 0);
    send(0, 40, 2, 0);
    send(0, 20, 3, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_sig",      64'(out_signature), 64'd10);
      check("bp_idx",      64'(out_index), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    expect_out(0, 10, 1, 0);
    expect_out(0, 20, 3, 0);
    expect_out(0, 40, 2, 0);
    expect_out(0, 50, 0, 1);
    @(negedge clk);
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    check("bp_valid_after",    64'(out_valid), 64'd0);

    // Width edges
    send(0, 32'hFFFF_FFFF, 9, 1);
    @(negedge clk);
    check("single_count", 64'(sketch_count), 64'd1);
    expect_out(0, 32'hFFFF_FFFF, 9, 1);
    send(0, 32'h0000_0000, 1, 0);
    send(0, 32'hFFFF_FFFF, 2, 1);
    expect_out(0, 32'h0000_0000, 1, 0);
    expect_out(0, 32'hFFFF_FFFF, 2, 1);
    send(0, 32'hFFFF_FFFF, 3, 0);
    send(0, 32'h8000_0000, 4, 1);
    expect_out(0, 32'h8000_0000, 4, 0);
    expect_out(0, 32'hFFFF_FFFF, 3, 1);

    // Mid-drain reset
    send(0, 50, 0, 0);
    send(0, 10, 1, 0);
    send(0, 40, 2, 0);
    send(0, 20, 3, 1);
    expect_out(0, 10, 1, 0);
    expect_out(0, 20, 3, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid",    64'(out_valid), 64'd0);
    check("mid_rst_count",    64'(sketch_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_fill", 64'(in_ready), 64'd1);
    check("mid_rst_idle", 64'(out_valid), 64'd0);
    send(0, 3, 7, 0);
    send(0, 1, 8, 1);
    expect_out(0, 1, 8, 0);
    expect_out(0, 3, 7, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
